// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer driving an external 1-bit full adder/subtractor cell, LSB first.
// Optional: define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub_seq #(
   parameter int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             cell_a,
   output logic             cell_b,
   output logic             cell_sel,
   output logic             cell_cin,
   input  logic             cell_sum,
   input  logic             cell_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh, r_sh;
   logic [CNT_W-1:0] cnt;
   logic             carry, op, a_msb, b_msb;
   logic [WIDTH-1:0] r_next;
   logic             ovf_next;

   // Result as it will look once the current bit is shifted in
   assign r_next   = {cell_sum, r_sh[WIDTH-1:1]};
   assign ovf_next = op ? ((a_msb != b_msb) && (cell_sum != a_msb))
                        : ((a_msb == b_msb) && (cell_sum != a_msb));

   assign in_ready = (state == IDLE) && !rst;
   assign cell_a   = (state == RUN) && a_sh[0];
   assign cell_b   = (state == RUN) && b_sh[0];
   assign cell_cin = (state == RUN) && carry;
   assign cell_sel = op;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         r_sh       <= '0;
         cnt        <= '0;
         carry      <= 1'b0;
         op         <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_carry  <= 1'b0;
         out_ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= in_a;
                  b_sh  <= in_b;
                  op    <= in_sub;
                  a_msb <= in_a[WIDTH-1];
                  b_msb <= in_b[WIDTH-1];
                  carry <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               r_sh  <= r_next;
               carry <= cell_cout;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_carry <= cell_cout;
                  out_ovf   <= ovf_next;
`ifdef SERIAL_ADDSUB_SAT_EN
                  // Overflow direction always follows the sign of A in both modes
                  if (ovf_next)
                     out_result <= a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                  else
                     out_result <= r_next;
`else
                  out_result <= r_next;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Bench for serial_addsub_seq: behavioural mux cell, scoreboard queue of expected results.
module tb_serial_addsub_seq;

   logic        clk, rst;
   logic        in_valid, in_ready, in_sub;
   logic [15:0] in_a, in_b;
   logic        cell_a, cell_b, cell_sel, cell_cin, cell_sum, cell_cout;
   logic        out_valid, out_ready, out_carry, out_ovf;
   logic [15:0] out_result;

   typedef struct packed {
      logic [15:0] r;
      logic        c;
      logic        v;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   serial_addsub_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .cell_a(cell_a), .cell_b(cell_b), .cell_sel(cell_sel), .cell_cin(cell_cin),
      .cell_sum(cell_sum), .cell_cout(cell_cout),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_carry(out_carry), .out_ovf(out_ovf)
   );

   // Mux-based full adder / borrow subtractor cell
   assign cell_sum  = cell_a ^ cell_b ^ cell_cin;
   assign cell_cout = cell_sel ? ((~cell_a & cell_b) | (~(cell_a ^ cell_b) & cell_cin))
                               : ((cell_a & cell_b) | (cell_a & cell_cin) | (cell_b & cell_cin));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
      exp_t        e;
      logic [16:0] x;
      x   = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      e.r = x[15:0];
      e.c = s ? (a < b) : x[16];
      e.v = s ? ((a[15] != b[15]) && (x[15] != a[15])) : ((a[15] == b[15]) && (x[15] != a[15]));
`ifdef SERIAL_ADDSUB_SAT_EN
      if (e.v) e.r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
      return e;
   endfunction

   // Present operands at a negedge, hold until accepted, optionally record the expected result
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s, input bit push);
      int n;
      @(negedge clk);
      in_a = a; in_b = b; in_sub = s; in_valid = 1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL send_timeout: in_ready never rose for a=%h b=%h", a, b);
      end
      if (push) sb.push_back(model(a, b, s));
      @(negedge clk);
      in_valid = 0;
      in_a = $urandom; in_b = $urandom; in_sub = $urandom;
   endtask

   // Wait for a result (optionally with random backpressure) and compare with the scoreboard head
   task automatic recv(input string name, input bit rnd);
      int   n;
      exp_t e;
      n = 0;
      out_ready = rnd ? 1'($urandom) : 1'b1;
      while (!(out_valid && out_ready) && n < 300) begin
         @(negedge clk);
         out_ready = rnd ? 1'($urandom) : 1'b1;
         n++;
      end
      total++;
      if (n >= 300 || sb.size() == 0) begin
         bad++;
         $display("FAIL %s_timeout: out_valid=%b queued=%0d", name, out_valid, sb.size());
      end else begin
         e = sb.pop_front();
         if ({out_result, out_carry, out_ovf} !== {e.r, e.c, e.v}) begin
            bad++;
            $display("FAIL %s: got r=%h c=%b v=%b want r=%h c=%b v=%b",
                     name, out_result, out_carry, out_ovf, e.r, e.c, e.v);
         end
      end
      @(negedge clk);
      out_ready = 0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s_drop: out_valid got %b want 0", name, out_valid);
      end
   endtask

   task automatic test_reset;
      rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_sub = 0; out_ready = 0;
      #12;
      total++;
      if ({out_valid, out_result, out_carry, out_ovf, cell_a, cell_b, cell_cin, cell_sel} !== '0) begin
         bad++;
         $display("FAIL reset_outs: got v=%b r=%h c=%b o=%b", out_valid, out_result, out_carry, out_ovf);
      end
      @(negedge clk);
      rst = 0;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add;
      int k;
      send(16'h1234, 16'h0FF1, 0, 1);
      k = 1;
      while (!out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (k != 17) begin
         bad++;
         $display("FAIL add_latency: got %0d edges want 17", k);
      end
      total++;
      if ({out_result, out_carry, out_ovf} !== {16'h2225, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL add_const: got r=%h c=%b v=%b want r=2225 c=0 v=0", out_result, out_carry, out_ovf);
      end
      recv("add_basic", 0);
      send(16'h7FFF, 16'h0001, 0, 1);
      recv("add_ovf", 0);
   endtask

   task automatic test_sub;
      send(16'h0005, 16'h0007, 1, 1);
      recv("sub_borrow", 0);
      send(16'h8000, 16'h0001, 1, 1);
      recv("sub_ovf", 0);
   endtask

   task automatic test_backpressure;
      logic [17:0] snap;
      int          n;
      send(16'hA5A5, 16'h1111, 0, 1);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      snap = {out_result, out_carry, out_ovf};
      in_a = 16'h0F0F; in_b = 16'h0101; in_sub = 1; in_valid = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if ({out_valid, in_ready, out_result, out_carry, out_ovf} !== {1'b1, 1'b0, snap}) begin
            bad++;
            $display("FAIL bp_hold%0d: got v=%b rdy=%b r=%h want v=1 rdy=0 r=%h",
                     i, out_valid, in_ready, out_result, snap[17:2]);
         end
      end
      in_valid = 0;
      recv("bp_result", 0);
      total++;
      if (in_ready !== 1'b1 || sb.size() != 0) begin
         bad++;
         $display("FAIL bp_idle: in_ready got %b want 1, queued=%0d", in_ready, sb.size());
      end
      send(16'h0100, 16'h0023, 0, 1);
      recv("bp_next", 0);
   endtask

   task automatic test_reset_mid_run;
      send(16'hFFFF, 16'h0001, 0, 0);
      repeat (6) @(negedge clk);
      rst = 1;
      #1;
      total++;
      if ({out_valid, out_result, out_carry, out_ovf, cell_a, cell_b, cell_cin, cell_sel, in_ready} !== '0) begin
         bad++;
         $display("FAIL midrun_rst: got v=%b r=%h c=%b o=%b ca=%b cb=%b ci=%b rdy=%b",
                  out_valid, out_result, out_carry, out_ovf, cell_a, cell_b, cell_cin, in_ready);
      end
      repeat (2) @(negedge clk);
      rst = 0;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL midrun_release: rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      end
      send(16'h0003, 16'h0004, 0, 1);
      recv("midrun_fresh", 0);
   endtask

   task automatic test_back_to_back;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               send(16'($urandom), 16'($urandom), 1'($urandom), 1);
            end
         end
         begin
            for (int j = 0; j < 100; j++) recv("b2b", 1);
         end
      join
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL b2b_leftover: got %0d queued want 0", sb.size());
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_backpressure;
      test_reset_mid_run;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
